// File: rtl/wb_pkg.sv
// Shared constants and state encoding for the result write-back stage.
package wb_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } wb_state_t;
endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO buffering compute results ahead of the SRAM write port.
module wb_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign data_out = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PTR_W-1:0]] <= data_in;
    end
endmodule

// File: rtl/result_writeback.sv
// Write-back stage: buffers 16-bit results and writes them to the output SRAM
// at consecutive addresses from a programmable base, then pulses done.
//
// state  | meaning
// IDLE   | waiting for start; no results accepted
// RUN    | accepting results and writing them one per cycle
// FINISH | single cycle after the last write is registered; done follows
module result_writeback
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_results,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic              dut_sram_write_enable,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              busy,
    output logic              done
);
    wb_state_t         state;
    wb_state_t         state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              push;
    logic              pop;
    logic              last_pop;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              done_q;

    wb_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_b  (reset_b),
        .push     (push),
        .pop      (pop),
        .data_in  (res_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .data_out (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (!reset_b)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (num_results == '0) ? FINISH : RUN;
            RUN:     if (last_pop) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A full FIFO refuses input even when a pop is happening this cycle.
    always_comb begin
        res_ready = 1'b0;
        pop       = 1'b0;
        if (state == RUN) begin
            res_ready = !fifo_full && (acc_cnt < num_q);
            pop       = !fifo_empty;
        end
    end

    assign push     = res_valid && res_ready;
    assign last_pop = pop && ((wr_cnt + CNT_W'(1)) == num_q);

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            base_q    <= '0;
            num_q     <= '0;
            acc_cnt   <= '0;
            wr_cnt    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q  <= (state == FINISH);
            wr_en_q <= pop;
            if (state == IDLE && start) begin
                base_q  <= base_addr;
                num_q   <= {1'b0, num_results};
                acc_cnt <= '0;
                wr_cnt  <= '0;
            end
            if (push)
                acc_cnt <= acc_cnt + CNT_W'(1);
            if (pop) begin
                wr_addr_q <= base_q + wr_cnt[ADDR_W-1:0];
                wr_data_q <= fifo_head;
                wr_cnt    <= wr_cnt + CNT_W'(1);
            end
        end
    end

    assign dut_sram_write_enable  = wr_en_q;
    assign dut_sram_write_address = wr_addr_q;
    assign dut_sram_write_data    = wr_data_q;
    assign done                   = done_q;
    // The final write is still on the port while the FSM sits in FINISH.
    assign busy                   = (state == RUN) || wr_en_q;
endmodule
